pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, a synchronous flush that inserts a bubble, and an optional stall counter. Sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). A downstream stall back-pressures the upstream stage without losing data, and a branch or exception flush turns the stage into a NOP.

## Interface
Parameters:
- WIDTH, 32, bits of the data payload.
- NOP_VALUE, {WIDTH{1'b0}}, payload value presented while the stage is empty or after a flush/reset.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready at the clock edge.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready at the clock edge.
- out_data  output  WIDTH  head-entry payload.
- flush  input  1  synchronous discard of all held and incoming entries.
- stall_count  output  CNT_WIDTH  saturating count of stalled cycles (see Configuration).

## Operation
- Storage: main register M (drives out_data) and skid register S.
- States:
  - EMPTY: no valid entries.
  - ONE: M valid.
  - FULL: M and S valid.
- Output derivation, all from registers with no combinational in-to-out path:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - out_data = M.
- Transitions without flush (in = in_valid && in_ready, out = out_valid && out_ready):
  - EMPTY: in -> ONE, M <= in_data; otherwise hold.
  - ONE:
    - in && out -> ONE, M <= in_data.
    - in && !out -> FULL, S <= in_data.
    - !in && out -> EMPTY, M <= NOP_VALUE.
    - Otherwise hold.
  - FULL: out -> ONE, M <= S, S <= NOP_VALUE; otherwise hold. No accept is possible because in_ready = 0.
- flush has the highest priority:
  - Next state is EMPTY, M <= NOP_VALUE, S <= NOP_VALUE.
  - Any in or out handshake in the same cycle is discarded: the upstream item is dropped and the downstream item is not consumed by the stage.
  - in_ready and out_valid are not gated by flush in the flush cycle.
- Ordering is strictly FIFO: M is always older than S.
- Data changes only on an accepted transfer, a drain, a flush, or reset. No X is ever propagated from in_data unless it is accepted.

## Timing
- Reset (asynchronous, immediate): state EMPTY, M = S = NOP_VALUE, out_valid = 0, in_ready = 1, out_data = NOP_VALUE, stall_count = 0.
- Latency: an item accepted at edge N is on out_data with out_valid = 1 after edge N.
- Throughput: one item per cycle while out_ready stays high.
- Back-pressure: in_ready falls one cycle after the first stalled accept, absorbed by S. It rises one cycle after the downstream drains S.
- Reset asserted mid-operation aborts everything. First accept is possible at the first edge after rst deasserts.
- Flush on an EMPTY stage is a no-op apart from dropping that cycle's input.

## Configuration
- Macro PIPE_STAGE_REG_STATS_EN.
- Defined:
  - stall_count increments on every edge where out_valid && !out_ready.
  - It saturates at all-ones and is cleared only by rst; flush does not clear it.
- Not defined: the counter logic is removed and stall_count is tied to 0.

## Test plan
- Reset: with rst = 1 and NOP_VALUE = 32'h0000_0020, expect out_valid = 0, in_ready = 1, out_data = 32'h20. No change for 3 clocks.
- Streaming: out_ready = 1, send 0x1..0x8 back to back. Expect out_data 0x1..0x8 on consecutive cycles, one cycle behind input, in_ready held at 1.
- Stall/skid:
  - Send 0xA then 0xB with out_ready = 0. Expect state FULL, in_ready = 0, out_data = 0xA.
  - Raise out_ready. Expect 0xA, then 0xB, and in_ready = 1 one cycle after 0xA drains.
- Flush in FULL with in_valid = 1 and data 0xC: next cycle out_valid = 0, out_data = NOP_VALUE, and 0xC never appears at the output.
- Async reset mid-stream: assert rst between edges while FULL. Outputs go to reset values immediately; the next accept after release is passed through correctly.
- Stats (macro defined, CNT_WIDTH = 4): hold out_valid = 1 and out_ready = 0 for 20 cycles. Expect stall_count = 15 (saturated). Flush leaves it at 15. Without the macro it reads 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. It sits between MIPS pipeline stages such as IF/ID, ID/EX, EX/MEM
// and MEM/WB.
//   - A downstream stall back-pressures upstream one cycle later. The item
//     accepted during that cycle is held in the skid register.
//   - A synchronous flush empties the stage and turns it into a bubble.
//   - All outputs come straight from registers, so there is no
//     combinational path from input to output.
//
// Optional feature: define PIPE_STAGE_REG_STATS_EN to enable the saturating
// stall counter. When it is not defined, stall_count is tied to 0.
//
// Parameters:
//   WIDTH      payload width
//   NOP_VALUE  payload presented while empty, after a flush, or after reset
//   CNT_WIDTH  stall counter width
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     upstream presents in_data
//   in_ready     stage can accept (not FULL)
//   in_data      upstream payload
//   out_valid    out_data holds a valid entry (not EMPTY)
//   out_ready    downstream accepts the head entry
//   out_data     head-entry payload (main register)
//   flush        discards all held and incoming entries
//   stall_count  saturating count of edges with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_p0;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_p0;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_p0;
  logic [WIDTH-1:0] skid_nxt;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_p0 != EMPTY);
  assign in_ready  = (state_p0 != FULL);
  assign out_data  = main_p0;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next-state and register-update selection. in_data is only routed into a
  // register on an accepted transfer, so an idle X bus never leaks in.
  always_comb begin
    state_nxt = state_p0;
    main_nxt  = main_p0;
    skid_nxt  = skid_p0;
    if (flush) begin
      // Flush wins over both handshakes in the same cycle.
      state_nxt = EMPTY;
      main_nxt  = NOP_VALUE;
      skid_nxt  = NOP_VALUE;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
            main_nxt  = NOP_VALUE;
          end
        end
        FULL: begin
          // in_ready is low here, so the only possible event is a drain.
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_p0;
            skid_nxt  = NOP_VALUE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = NOP_VALUE;
          skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // ---- stage register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= EMPTY;
      main_p0  <= NOP_VALUE;
      skid_p0  <= NOP_VALUE;
    end else begin
      state_p0 <= state_nxt;
      main_p0  <= main_nxt;
      skid_p0  <= skid_nxt;
    end
  end

`ifdef PIPE_STAGE_REG_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [CNT_WIDTH-1:0] stall_cnt_p0;

  // Flush deliberately does not clear the counter; only reset does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_p0 <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  assign stall_count = stall_cnt_p0;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int          WIDTH = 32;
  localparam int          CW    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0020;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    stall_count;

  int tests = 0;
  int fails = 0;

  // Reference model: the stage is an ordered queue holding at most two items.
  logic [WIDTH-1:0] q[$];
  int               m_cnt = 0;

  pipe_stage_reg #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP),
    .CNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] ed;
    int               ec;
    ed = (q.size() > 0) ? q[0] : NOP;
`ifdef PIPE_STAGE_REG_STATS_EN
    ec = m_cnt;
`else
    ec = 0;
`endif
    chk1({tag, ".out_valid"}, {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    chk1({tag, ".in_ready"},  {31'd0, in_ready},  (q.size() < 2) ? 32'd1 : 32'd0);
    chk1({tag, ".out_data"},  out_data, ed);
    chk1({tag, ".stall_count"}, {28'd0, stall_count}, ec);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and check.
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic ordy, input logic fl);
    bit do_in;
    bit do_out;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    do_in  = v && (q.size() < 2);
    do_out = ordy && (q.size() > 0);
    if (q.size() > 0 && !ordy && m_cnt < (1 << CW) - 1) m_cnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    #1;
    check_all("reset");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_0000 + i;
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    rst = 1'b0;

    // Streaming: back-to-back items, one cycle of latency.
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, i, 1'b1, 1'b0);
    chk1("stream_last", out_data, 32'h8);
    step("stream_drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // Stall and skid.
    step("skid_a", 1'b1, 32'hA, 1'b0, 1'b0);
    step("skid_b", 1'b1, 32'hB, 1'b0, 1'b0);
    chk1("skid_full_ready", {31'd0, in_ready}, 32'd0);
    chk1("skid_full_head", out_data, 32'hA);
    step("skid_drain_a", 1'b0, 32'h0, 1'b1, 1'b0);
    chk1("skid_head_b", out_data, 32'hB);
    step("skid_drain_b", 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL with a concurrent incoming item.
    step("fl_fill_a", 1'b1, 32'hA, 1'b0, 1'b0);
    step("fl_fill_b", 1'b1, 32'hB, 1'b0, 1'b0);
    step("flush_full", 1'b1, 32'hC, 1'b1, 1'b1);
    chk1("flush_data", out_data, NOP);
    for (int i = 0; i < 3; i++) step("post_flush", 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush on an empty stage drops that cycle's input.
    step("flush_empty", 1'b1, 32'hE, 1'b1, 1'b1);

    // Asynchronous reset mid-stream while FULL.
    step("ar_fill_a", 1'b1, 32'h11, 1'b0, 1'b0);
    step("ar_fill_b", 1'b1, 32'h22, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 0;
    check_all("async_reset");
    #1;
    rst = 1'b0;
    step("ar_accept", 1'b1, 32'h55, 1'b1, 1'b0);
    chk1("ar_pass", out_data, 32'h55);
    step("ar_drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step("random", ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    // Stall counter saturation: reset, load one item, then stall 20 cycles.
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 0;
    rst = 1'b0;
    step("stat_load", 1'b1, 32'h77, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("stat_stall", 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_REG_STATS_EN
    chk1("stat_sat", {28'd0, stall_count}, 32'd15);
`else
    chk1("stat_off", {28'd0, stall_count}, 32'd0);
`endif
    step("stat_flush", 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef PIPE_STAGE_REG_STATS_EN
    chk1("stat_after_flush", {28'd0, stall_count}, 32'd15);
`else
    chk1("stat_after_flush", {28'd0, stall_count}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
